// File: rtl/boot_loader_if.sv
// boot_loader_if
//   Bundles the boot loader's control, byte-stream and icache boot-port
//   signals so they can travel as one port.
//   slave  : the loader side (boot_loader).
//   master : the side that drives start/abort/stream and watches the boot port.
// Signals:
//   start, word_count, abort       load control (word_count sampled on start)
//   rx_valid, rx_data, rx_ready    byte stream handshake
//   boot_up, boot_addr,
//   boot_datai, boot_web           icache boot port (boot_web active-low)
//   busy, done, err                load status (done/err are one-cycle pulses)
interface boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
);
  logic              start;
  logic [CNT_W-1:0]  word_count;
  logic              abort;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              boot_up;
  logic [ADDR_W-1:0] boot_addr;
  logic [31:0]       boot_datai;
  logic              boot_web;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, word_count, abort, rx_valid, rx_data,
    output rx_ready, boot_up, boot_addr, boot_datai, boot_web, busy, done, err
  );

  modport master (
    output start, word_count, abort, rx_valid, rx_data,
    input  rx_ready, boot_up, boot_addr, boot_datai, boot_web, busy, done, err
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader
//   Feeds the instruction cache boot port from a byte stream. Bytes arrive
//   over a valid/ready handshake and are packed little-endian into 32-bit
//   words; every completed word is written to the icache with a one-cycle
//   active-low write strobe. boot_up stays high for the whole load so the
//   core is held in boot, and drops once the requested number of words has
//   been written. An idle stream (TIMEOUT cycles without a byte) or an abort
//   ends the load with an err pulse; words already written stay written.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   io_bus  boot_loader_if.slave: control, byte stream, icache port, status
module boot_loader #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  boot_loader_if.slave  io_bus
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [IDLE_W-1:0] r_idle_cnt;

  logic              r_rx_ready;
  logic              r_boot_up;
  logic [ADDR_W-1:0] r_boot_addr;
  logic [31:0]       r_boot_datai;
  logic              r_boot_web;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_count_ok;
  logic              w_last;
  logic              w_timeout;
  logic              w_fail;
  logic [2:0]        w_lane_we;
  logic [23:0]       w_word;

  // rx_ready is only ever high in COLLECT, so it alone qualifies a byte.
  assign w_accept   = io_bus.rx_valid && r_rx_ready && (r_state == S_COLLECT);
  assign w_count_ok = (io_bus.word_count != '0) &&
                      (io_bus.word_count <= CNT_W'(2 ** ADDR_W));
  assign w_last     = (r_word_idx == (r_count - CNT_W'(1)));
  assign w_timeout  = (r_state == S_COLLECT) && !w_accept &&
                      (r_idle_cnt == IDLE_W'(TIMEOUT - 1));
  // Abort beats everything in COLLECT/WRITE; the WRITE strobe already on the
  // port for this cycle still lands in the icache.
  assign w_fail     = (io_bus.abort &&
                       ((r_state == S_COLLECT) || (r_state == S_WRITE))) ||
                      w_timeout;

  // Byte lanes 0..2 are held here; lane 3 goes straight from rx_data into
  // the write data register on the accepting edge.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_lane
    logic [7:0] r_byte;

    assign w_lane_we[gi] = w_accept && (r_byte_idx == 2'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_byte <= '0;
      end else if (w_lane_we[gi]) begin
        r_byte <= io_bus.rx_data;
      end
    end

    assign w_word[8*gi +: 8] = r_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_idle_cnt   <= '0;
      r_rx_ready   <= 1'b0;
      r_boot_up    <= 1'b0;
      r_boot_addr  <= '0;
      r_boot_datai <= '0;
      r_boot_web   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      if (w_fail) begin
        r_state    <= S_IDLE;
        r_rx_ready <= 1'b0;
        r_boot_up  <= 1'b0;
        r_boot_web <= 1'b1;
        r_busy     <= 1'b0;
        r_err      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (io_bus.start) begin
              if (w_count_ok) begin
                r_state    <= S_COLLECT;
                r_count    <= io_bus.word_count;
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_idle_cnt <= '0;
                r_rx_ready <= 1'b1;
                r_boot_up  <= 1'b1;
                r_busy     <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end

          S_COLLECT: begin
            if (w_accept) begin
              r_idle_cnt <= '0;
              r_byte_idx <= r_byte_idx + 2'd1;
              if (r_byte_idx == 2'd3) begin
                // Present the write on the port for the WRITE cycle itself.
                r_state      <= S_WRITE;
                r_rx_ready   <= 1'b0;
                r_boot_web   <= 1'b0;
                r_boot_addr  <= r_word_idx[ADDR_W-1:0];
                r_boot_datai <= {io_bus.rx_data, w_word};
              end
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end

          S_WRITE: begin
            r_boot_web <= 1'b1;
            r_word_idx <= r_word_idx + CNT_W'(1);
            if (w_last) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_COLLECT;
              r_byte_idx <= '0;
              r_idle_cnt <= '0;
              r_rx_ready <= 1'b1;
            end
          end

          S_FINISH: begin
            r_state   <= S_IDLE;
            r_boot_up <= 1'b0;
            r_busy    <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign io_bus.rx_ready   = r_rx_ready;
  assign io_bus.boot_up    = r_boot_up;
  assign io_bus.boot_addr  = r_boot_addr;
  assign io_bus.boot_datai = r_boot_datai;
  assign io_bus.boot_web   = r_boot_web;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.err        = r_err;

endmodule
